hbridge_deadtime: RTL and testbench

Converts the DIR/PWM pair produced by the joint PWM/DIR generator into four gate-drive signals for a full H-bridge, using sign-magnitude drive with low-side recirculation. Every change of the switching configuration passes through a programmable dead interval, so the high and low switch of a leg are never on together. A synchronised, latched fault input forces all switches off. Sits between the joint PWM stage and the output pins of the motor bridge.

---
 rtl/hbridge_deadtime.sv | 141 ++++++++++++++
 tb/tb_hbridge_deadtime.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/hbridge_deadtime.sv
// Sign-magnitude H-bridge gate driver with low-side recirculation, programmable
// dead interval on every configuration change, and a latched, synchronised fault.
module hbridge_deadtime #(
  parameter int unsigned DEADTIME = 50
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic DIR,
  input  logic PWM,
  input  logic fault_n,
  output logic HA,
  output logic LA,
  output logic HB,
  output logic LB,
  output logic fault
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FWD  = 3'd1,
    S_REV  = 3'd2,
    S_LOW  = 3'd3,
    S_DEAD = 3'd4
  } state_t;

  localparam logic [15:0] RELOAD = 16'(DEADTIME - 32'd1);

  // Gate vector ordering is {HA, LA, HB, LB}.
  function automatic logic [3:0] gate_set(input state_t s);
    logic [3:0] g;
    case (s)
      S_FWD:   g = 4'b1001;
      S_REV:   g = 4'b0110;
      S_LOW:   g = 4'b0101;
      default: g = 4'b0000;
    endcase
    return g;
  endfunction

  state_t      state_r, prev_r, target_r;
  state_t      state_s, prev_s, target_s, desired_s;
  logic [15:0] cnt_r, cnt_s;
  logic        sync1_r, sync2_r;
  logic        fault_r, fault_s;
  logic [3:0]  gates_r, gates_s;

  // Fault latch update and desired drive configuration.
  always_comb begin
    fault_s   = fault_r;
    desired_s = S_IDLE;
    if (!sync2_r) begin
      fault_s = 1'b1;
    end else if (!enable) begin
      fault_s = 1'b0;
    end else begin
      fault_s = fault_r;
    end
    if (!enable || fault_s) begin
      desired_s = S_IDLE;
    end else if (PWM && DIR) begin
      desired_s = S_FWD;
    end else if (PWM) begin
      desired_s = S_REV;
    end else begin
      desired_s = S_LOW;
    end
  end

  // Next state, dead-interval bookkeeping and next gate vector.
  always_comb begin
    state_s  = state_r;
    prev_s   = prev_r;
    target_s = target_r;
    cnt_s    = cnt_r;
    gates_s  = 4'b0000;
    if (desired_s == S_IDLE) begin
      state_s = S_IDLE;
    end else begin
      case (state_r)
        S_DEAD: begin
          // A new target restarts the full interval; prev stays the last driven state.
          if (desired_s != target_r) begin
            target_s = desired_s;
            cnt_s    = RELOAD;
          end else if (cnt_r == 16'd0) begin
            state_s = target_r;
          end else begin
            cnt_s = cnt_r - 16'd1;
          end
        end
        S_IDLE, S_FWD, S_REV, S_LOW: begin
          if (desired_s != state_r) begin
            state_s  = S_DEAD;
            prev_s   = state_r;
            target_s = desired_s;
            cnt_s    = RELOAD;
          end else begin
            state_s = state_r;
          end
        end
        default: state_s = S_IDLE;
      endcase
    end
    if (state_s == S_DEAD) begin
      gates_s = gate_set(prev_s) & gate_set(target_s);
    end else begin
      gates_s = gate_set(state_s);
    end
  end

  // State, counter, synchroniser, fault latch and registered gate outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= S_IDLE;
      prev_r   <= S_IDLE;
      target_r <= S_IDLE;
      cnt_r    <= 16'd0;
      sync1_r  <= 1'b1;
      sync2_r  <= 1'b1;
      fault_r  <= 1'b0;
      gates_r  <= 4'b0000;
    end else begin
      state_r  <= state_s;
      prev_r   <= prev_s;
      target_r <= target_s;
      cnt_r    <= cnt_s;
      sync1_r  <= fault_n;
      sync2_r  <= sync1_r;
      fault_r  <= fault_s;
      gates_r  <= gates_s;
    end
  end

  assign HA    = gates_r[3];
  assign LA    = gates_r[2];
  assign HB    = gates_r[1];
  assign LB    = gates_r[0];
  assign fault = fault_r;

endmodule

// File: tb/tb_hbridge_deadtime.sv
// Directed scoreboard bench (DEADTIME=50) plus a randomised safety run on a
// second instance (DEADTIME=3) checking shoot-through and partner-off gaps.
module tb_hbridge_deadtime;

  logic clk = 1'b0;
  logic reset, enable, dir, pwm, fault_n;
  logic ha, la, hb, lb, fault;
  logic reset2, enable2, dir2, pwm2, fault_n2;
  logic ha2, la2, hb2, lb2, fault2;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      tag;
    logic [4:0] val;
  } exp_t;
  exp_t sb_q[$];

  int         last_fall[4];
  logic [3:0] pg;
  logic [3:0] g2;

  always #5 clk = ~clk;

  hbridge_deadtime #(.DEADTIME(50)) dut (
    .clk(clk), .reset(reset), .enable(enable), .DIR(dir), .PWM(pwm),
    .fault_n(fault_n), .HA(ha), .LA(la), .HB(hb), .LB(lb), .fault(fault)
  );

  hbridge_deadtime #(.DEADTIME(3)) dut_fast (
    .clk(clk), .reset(reset2), .enable(enable2), .DIR(dir2), .PWM(pwm2),
    .fault_n(fault_n2), .HA(ha2), .LA(la2), .HB(hb2), .LB(lb2), .fault(fault2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_safe(string tag, logic [3:0] g);
    checks += 3;
    assert (!(g[3] && g[2])) else begin
      errors++;
      $error("FAIL %s_legA: gates=%b required HA&LA=0", tag, g);
    end
    assert (!(g[1] && g[0])) else begin
      errors++;
      $error("FAIL %s_legB: gates=%b required HB&LB=0", tag, g);
    end
    assert (!(g[3] && g[1])) else begin
      errors++;
      $error("FAIL %s_highs: gates=%b required HA&HB=0", tag, g);
    end
  endtask

  // Queue n expected {HA,LA,HB,LB,fault} vectors, then retire one per clock.
  task automatic expect_n(int n, logic [3:0] g, logic f, string tag);
    exp_t e;
    exp_t got;
    logic [4:0] obs;
    for (int i = 0; i < n; i++) begin
      e.tag = tag;
      e.val = {g, f};
      sb_q.push_back(e);
    end
    for (int i = 0; i < n; i++) begin
      tick();
      got = sb_q.pop_front();
      obs = {ha, la, hb, lb, fault};
      checks++;
      assert (obs === got.val) else begin
        errors++;
        $error("FAIL %s[%0d]: got %b expected %b", got.tag, i, obs, got.val);
      end
      check_safe(got.tag, obs[4:1]);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; dir = 1'b0; pwm = 1'b0; fault_n = 1'b1;
    reset2 = 1'b1; enable2 = 1'b0; dir2 = 1'b0; pwm2 = 1'b0; fault_n2 = 1'b1;
    tick();
    expect_n(2, 4'b0000, 1'b0, "reset");

    reset = 1'b0; enable = 1'b1;
    expect_n(50, 4'b0000, 1'b0, "pwr_dead");
    expect_n(5, 4'b0101, 1'b0, "low");

    dir = 1'b1; pwm = 1'b1;
    expect_n(50, 4'b0001, 1'b0, "low2fwd_dead");
    expect_n(150, 4'b1001, 1'b0, "fwd");
    pwm = 1'b0;
    expect_n(50, 4'b0001, 1'b0, "fwd2low_dead");
    expect_n(10, 4'b0101, 1'b0, "low2");

    pwm = 1'b1;
    expect_n(50, 4'b0001, 1'b0, "low2fwd_dead2");
    expect_n(10, 4'b1001, 1'b0, "fwd2");
    dir = 1'b0;
    expect_n(50, 4'b0000, 1'b0, "fwd2rev_dead");
    expect_n(10, 4'b0110, 1'b0, "rev");

    // FWD -> LOW interrupted at cycle 20: target back to FWD, prev FWD keeps HA.
    dir = 1'b1;
    expect_n(50, 4'b0000, 1'b0, "rev2fwd_dead");
    expect_n(10, 4'b1001, 1'b0, "fwd3");
    pwm = 1'b0;
    expect_n(20, 4'b0001, 1'b0, "fwd2low_part");
    pwm = 1'b1;
    expect_n(60, 4'b1001, 1'b0, "retarget_fwd");
    pwm = 1'b0;
    expect_n(50, 4'b0001, 1'b0, "fwd2low_dead3");
    expect_n(5, 4'b0101, 1'b0, "low3");

    // LOW -> FWD retargeted to REV at cycle 20: counter reloads, LOW&REV = LA.
    pwm = 1'b1;
    expect_n(20, 4'b0001, 1'b0, "low2fwd_part");
    dir = 1'b0;
    expect_n(50, 4'b0100, 1'b0, "retarget_rev");
    expect_n(5, 4'b0110, 1'b0, "rev2");

    // One-cycle fault pulse: gates off on the third clock and latched.
    fault_n = 1'b0;
    expect_n(1, 4'b0110, 1'b0, "fault_sync1");
    fault_n = 1'b1;
    expect_n(1, 4'b0110, 1'b0, "fault_sync2");
    expect_n(20, 4'b0000, 1'b1, "fault_off");
    enable = 1'b0;
    expect_n(2, 4'b0000, 1'b0, "fault_clr");
    enable = 1'b1;
    expect_n(50, 4'b0000, 1'b0, "reenter_dead");
    expect_n(5, 4'b0110, 1'b0, "rev3");

    enable = 1'b0;
    expect_n(3, 4'b0000, 1'b0, "en_low");
    enable = 1'b1;
    expect_n(50, 4'b0000, 1'b0, "en_dead");
    expect_n(3, 4'b0110, 1'b0, "rev4");

    // Reset in the middle of DEAD (REV -> LOW holds LA).
    pwm = 1'b0;
    expect_n(10, 4'b0100, 1'b0, "rev2low_dead");
    reset = 1'b1;
    expect_n(2, 4'b0000, 1'b0, "rst_dead");
    reset = 1'b0;
    expect_n(50, 4'b0000, 1'b0, "rst_dead_re");
    expect_n(5, 4'b0101, 1'b0, "low4");

    // Pulse shorter than the dead interval never reaches the high side.
    dir = 1'b1; pwm = 1'b1;
    expect_n(10, 4'b0001, 1'b0, "short_pulse");
    pwm = 1'b0;
    expect_n(55, 4'b0101, 1'b0, "short_back");

    // Reset while driving forward.
    pwm = 1'b1;
    expect_n(50, 4'b0001, 1'b0, "low2fwd_dead4");
    expect_n(5, 4'b1001, 1'b0, "fwd4");
    reset = 1'b1;
    expect_n(2, 4'b0000, 1'b0, "rst_fwd");
    reset = 1'b0; enable = 1'b0;
    expect_n(2, 4'b0000, 1'b0, "idle");

    // Random drive of the fast instance with safety and gap checks.
    tick();
    reset2 = 1'b0;
    pg = 4'b0000;
    for (int i = 0; i < 4; i++) last_fall[i] = -1000;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      if ($urandom_range(7, 0) == 0) pwm2 = ~pwm2;
      if ($urandom_range(15, 0) == 0) dir2 = ~dir2;
      enable2  = ($urandom_range(99, 0) != 0);
      fault_n2 = ($urandom_range(499, 0) != 0);
      tick();
      g2 = {ha2, la2, hb2, lb2};
      check_safe("rand", g2);
      for (int i = 0; i < 4; i++) begin
        if (pg[i] && !g2[i]) last_fall[i] = cyc;
      end
      for (int i = 0; i < 4; i++) begin
        if (!pg[i] && g2[i]) begin
          checks++;
          assert (cyc - last_fall[i ^ 1] >= 3) else begin
            errors++;
            $error("FAIL rand_gap: gate %0d rose %0d cycles after partner fell, required >=3",
                   i, cyc - last_fall[i ^ 1]);
          end
        end
      end
      pg = g2;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
